// File: rtl/lifo_reader_pkg.sv
// Shared types and constants for the LIFO read-side controller.
package lifo_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } lifo_reader_state_t;

   localparam int LIFO_RD_LATENCY = 1;
   localparam int BUF_DEPTH       = 2;
   localparam int CNT_W           = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/lifo_reader_buf.sv
// Two-entry FIFO that absorbs LIFO read latency; head word is presented with valid/ready.
module lifo_reader_buf
   import lifo_reader_pkg::*;
#(
   parameter int DWIDTH = 16
) (
   input  logic              i_clk,
   input  logic              i_srst,
   input  logic              i_wr_en,
   input  logic [DWIDTH-1:0] i_wr_data,
   input  logic              i_rd_ready,
   output logic [DWIDTH-1:0] o_rd_data,
   output logic              o_rd_valid
);

   logic [DWIDTH-1:0] r_mem [BUF_DEPTH];
   logic              r_wptr;
   logic              r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_pop;

   assign w_pop      = (r_count != '0) && i_rd_ready;
   assign o_rd_valid = (r_count != '0);
   assign o_rd_data  = r_mem[r_rptr];

   // The controller's pop rule keeps occupancy at or below BUF_DEPTH, so no full check here.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= '0;
      end else begin
         if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_count <= r_count + CNT_W'(i_wr_en) - CNT_W'(w_pop);
      end
   end

endmodule

// File: rtl/lifo_reader.sv
// Pops a commanded number of words from a LIFO and streams them out newest-first.
//  state | meaning
//  IDLE  | waiting for start
//  READ  | issuing pops and draining words
//  FLUSH | all pops issued, draining remaining words
//  DONE  | one-cycle done pulse, then back to IDLE
module lifo_reader
   import lifo_reader_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              start,
   input  logic [AWIDTH:0]   len,
   output logic              busy,
   output logic              done,
   output logic              lifo_rdreq,
   input  logic [DWIDTH-1:0] lifo_q,
   input  logic              lifo_empty,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam logic [AWIDTH:0]  REM_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

   lifo_reader_state_t r_state;
   logic [AWIDTH:0]    r_rem_req;
   logic [AWIDTH:0]    r_rem_out;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_rd_pend;
   logic               r_busy;
   logic               r_done;
   logic               w_hs;
   logic               w_rdreq;

   assign w_hs = out_valid && out_ready;

   // A same-cycle handshake frees a slot, which is what sustains one pop per cycle.
   assign w_rdreq = !srst && (r_state == ST_READ) && (r_rem_req != '0) && !lifo_empty
                    && ((r_cnt < CNT_FULL) || w_hs);

   assign lifo_rdreq = w_rdreq;
   assign out_last   = (r_rem_out == REM_ONE);
   assign busy       = r_busy;
   assign done       = r_done;

   lifo_reader_buf #(
      .DWIDTH (DWIDTH)
   ) u_buf (
      .i_clk      (clk),
      .i_srst     (srst),
      .i_wr_en    (r_rd_pend),
      .i_wr_data  (lifo_q),
      .i_rd_ready (out_ready),
      .o_rd_data  (out_data),
      .o_rd_valid (out_valid)
   );

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state   <= ST_IDLE;
         r_rem_req <= '0;
         r_rem_out <= '0;
         r_cnt     <= '0;
         r_rd_pend <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_rd_pend <= w_rdreq;
         r_cnt     <= r_cnt + CNT_W'(w_rdreq) - CNT_W'(w_hs);
         r_done    <= 1'b0;
         if (w_rdreq) r_rem_req <= r_rem_req - REM_ONE;
         if (w_hs)    r_rem_out <= r_rem_out - REM_ONE;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (len != '0) begin
                     r_rem_req <= len;
                     r_rem_out <= len;
                     r_state   <= ST_READ;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_READ: begin
               if (w_hs && out_last) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if ((r_rem_req == '0) || (w_rdreq && (r_rem_req == REM_ONE))) begin
                  r_state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (w_hs && out_last) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
